// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, a slave on the CPU data bus.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_mmio #(
   parameter int          CLK_DIV    = 868,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [3:0]  sel,
   input  logic [31:0] addr,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        tx,
   output logic        irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic          r_ovf, r_en, r_irq_en, r_irq, r_tx, r_par;
   state_t        r_state;
   logic [DW-1:0] r_div;
   logic [7:0]    r_shift;
   logic [2:0]    r_idx;

   logic          w_hit, w_wr, w_push, w_push_ok, w_pop, w_empty, w_full, w_bit_end, w_busy;
   logic [1:0]    w_off;
   logic [4:0]    w_cnt5;
   logic [7:0]    w_head;
   logic          w_unused;

   assign w_hit     = ce & (addr[31:4] == BASE_ADDR[31:4]);
   assign w_off     = addr[3:2];
   assign w_wr      = w_hit & we;
   assign w_push    = w_wr & sel[0] & (w_off == 2'd0);
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_bit_end = (r_div == '0);
   assign w_busy    = (r_state != S_IDLE);
   assign w_head    = r_mem[r_rptr];
   // A new frame may start from IDLE or exactly where a stop bit ends.
   assign w_pop     = r_en & ~w_empty &
                      ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_cnt5    = 5'(r_count);
   assign w_unused  = ^{sel[3:1], addr[1:0], data_i[31:8]};

   always_comb begin
      data_o = '0;
      if (w_hit && !we) begin
         case (w_off)
            2'd1:    data_o = {23'b0, w_cnt5, r_ovf, w_busy, w_empty, w_full};
            2'd2:    data_o = {30'b0, r_irq_en, r_en};
            default: data_o = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= data_i[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + AW'(1);
         if (w_pop)     r_rptr <= r_rptr + AW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_push && !w_push_ok)
            r_ovf <= 1'b1;
         else if (w_wr && w_off == 2'd1 && data_i[3])
            r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_en     <= 1'b1;
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr && sel[0] && w_off == 2'd2) begin
            r_en     <= data_i[0];
            r_irq_en <= data_i[1];
         end
         r_irq <= r_irq_en & w_empty & ~w_busy;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_tx    <= 1'b1;
         r_div   <= '0;
         r_shift <= '0;
         r_idx   <= '0;
         r_par   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state <= S_START;
                  r_tx    <= 1'b0;
                  r_div   <= DW'(CLK_DIV - 1);
                  r_shift <= w_head;
                  r_par   <= ^w_head;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state <= S_DATA;
                  r_tx    <= r_shift[0];
                  r_div   <= DW'(CLK_DIV - 1);
                  r_idx   <= '0;
               end else
                  r_div <= r_div - DW'(1);
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_div <= DW'(CLK_DIV - 1);
                  if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_tx    <= r_par;
`else
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_tx    <= r_shift[1];
                     r_shift <= r_shift >> 1;
                     r_idx   <= r_idx + 3'd1;
                  end
               end else
                  r_div <= r_div - DW'(1);
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                  r_div   <= DW'(CLK_DIV - 1);
               end else
                  r_div <= r_div - DW'(1);
            end
`endif
            S_STOP: begin
               if (w_bit_end) begin
                  if (w_pop) begin
                     r_state <= S_START;
                     r_tx    <= 1'b0;
                     r_div   <= DW'(CLK_DIV - 1);
                     r_shift <= w_head;
                     r_par   <= ^w_head;
                  end else
                     r_state <= S_IDLE;
               end else
                  r_div <= r_div - DW'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx  = r_tx;
   assign irq = r_irq;

endmodule
